axi4_modport_checker: RTL and testbench
=======================================

// Module: axi4_modport_checker
// PURPOSE
//  Passive AXI4 protocol checker attached to the monitor view of an AXI4 link (all inputs, no drive).
//  Checks VALID stability, exclusive-access alignment, 4KB crossing and WRAP length rules each cycle.
//  Reports sticky per-rule error flags, a one-cycle error pulse and a saturating error count.
//  Sits beside any master/slave pair in the fabric or testbench; purely observational.
// PARAMETERS
//  ADDR_WIDTH  32  address width (>=13)
//  DATA_WIDTH  64  data width (multiple of 8; STRB = DATA_WIDTH/8)
//  ID_WIDTH    4   transaction ID width
// PORTS
//  aclk     in   1   clock, all logic on rising edge
//  areset   in   1   synchronous, active-high reset
//  aw*      in   -   awid[ID],awaddr[ADDR],awlen[8],awsize[3],awburst[2],awlock,awcache[4],awprot[3],awqos[4],awregion[4],awvalid,awready
//  w*       in   -   wdata[DATA],wstrb[STRB],wlast,wvalid,wready
//  b*       in   -   bid[ID],bresp[2],bvalid,bready
//  ar*      in   -   arid,araddr,arlen,arsize,arburst,arlock,arcache,arprot,arqos,arregion,arvalid,arready (widths as aw*)
//  r*       in   -   rid[ID],rdata[DATA],rresp[2],rlast,rvalid,rready
//  err_clr  in   1   clears err_flags and err_count (not the pulse)
//  err_flags out 8   sticky rule-violation flags (bit map below)
//  err_pulse out 1   high one cycle after any rule fires
//  err_count out 16  number of cycles with >=1 violation, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (areset=1 at edge): err_flags=0, err_pulse=0, err_count=0, all history regs=0. Reset wins over err_clr.
//  History: register xVALID and xREADY of all 5 channels each cycle (prev_v, prev_r).
//  Flag map (detection in cycle N -> registered visible at N+1):
//   [0] AW stab: prev_awvalid & !prev_awready & !awvalid   [1] W stab (same with w)
//   [2] AR stab   [3] B stab   [4] R stab
//   [5] EXCL: awvalid & awlock & !(awsize>=3 & awaddr[awsize-1:0]==0); sizes 0..2 always violate
//   [6] 4KB: (awvalid|arvalid) & burst==INCR(2'b01) & addr[ADDR-1:12] != end[ADDR-1:12],
//       end = addr + ((len+1)<<size) - 1, computed in ADDR_WIDTH+12 bits; FIXED and WRAP never flag
//   [7] WRAP: valid & burst==WRAP(2'b10) & len not in {1,3,7,15}; AW and AR both checked
//  Rules [5]-[7] evaluated every cycle VALID is high (a stalled bad request re-fires each cycle).
//  Burst code 2'b11 (reserved) not flagged by this block.
//  Stability rules ignore cycle after reset (history regs are 0).
//  err_flags <= (err_clr ? 0 : err_flags) | detect; detect in same cycle as err_clr still sets.
//  err_pulse <= |detect. err_count <= (err_clr ? 0 : err_count) + (|detect), saturating.
//  Multiple rules in one cycle: all bits set, count +1 only.
//  No combinational path input->output; latency exactly 1 cycle.
// TESTING
//  awvalid=1,awready=0 @N; awvalid=0 @N+1 -> err_flags[0]=1,err_pulse=1 @N+2, count=1.
//  awvalid,awlock=1,awsize=3,awaddr=0x1004 -> flag[5]; awaddr=0x1008 -> no error.
//  arvalid,INCR,araddr=0x0FF0,arlen=3,arsize=3 (end 0x100F) -> flag[6]; araddr=0x0FE0 -> none.
//  awvalid,WRAP,awlen=2 -> flag[7]; awlen=3 -> none; FIXED len=2 -> none.
//  hold bad AR 3 cycles -> count=3; err_clr one cycle w/o violation -> flags=0,count=0.
//  force 70000 violating cycles -> err_count stays 16'hFFFF; assert areset mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi4_modport_checker_if.sv
// AXI4 link bundle shared by master, slave and passive observers.
// The monitor modport is all-input so checkers can sit on any link without driving it.
interface axi4_modport_checker_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic [3:0]            awqos;
   logic [3:0]            awregion;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic [3:0]            arqos;
   logic [3:0]            arregion;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport monitor (
      input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid, awready,
      input wdata, wstrb, wlast, wvalid, wready,
      input bid, bresp, bvalid, bready,
      input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid, arready,
      input rid, rdata, rresp, rlast, rvalid, rready
   );
endinterface

// File: rtl/axi4_modport_checker.sv
// Passive AXI4 rule checker: VALID stability, exclusive alignment, 4KB crossing and WRAP length.
// Violations are registered into sticky flags, a one-cycle pulse and a saturating cycle count.
module axi4_modport_checker #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input  logic                          aclk,
   input  logic                          areset,
   axi4_modport_checker_if.monitor       bus,
   input  logic                          err_clr,
   output logic [7:0]                    err_flags,
   output logic                          err_pulse,
   output logic [15:0]                   err_count
);
   localparam int EW = ADDR_WIDTH + 12;

   if (ADDR_WIDTH < 13 || DATA_WIDTH % 8 != 0 || ID_WIDTH < 1) begin : g_bad_params
      $error("axi4_modport_checker: unsupported parameter set");
   end

   logic [4:0] prev_v;
   logic [4:0] prev_r;
   logic [4:0] cur_v;
   logic [4:0] cur_r;
   logic [7:0] detect;
   logic [15:0] count_base;

   // Last byte is computed in a widened space so bursts running off the top of the map still flag.
   function automatic logic crosses_4k(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [7:0] len, input logic [2:0] size);
      logic [EW-1:0] last;
      last = EW'(addr) + ((EW'(len) + EW'(1)) << size) - EW'(1);
      return last[ADDR_WIDTH-1:12] != addr[ADDR_WIDTH-1:12];
   endfunction

   function automatic logic excl_bad(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size);
      logic [ADDR_WIDTH-1:0] mask;
      mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
      return (size < 3'd3) || ((addr & mask) != '0);
   endfunction

   function automatic logic wrap_len_bad(input logic [7:0] len);
      return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
   endfunction

   assign cur_v = {bus.rvalid, bus.bvalid, bus.arvalid, bus.wvalid, bus.awvalid};
   assign cur_r = {bus.rready, bus.bready, bus.arready, bus.wready, bus.awready};

   always_comb begin
      detect      = '0;
      detect[4:0] = prev_v & ~prev_r & ~cur_v;
      detect[5]   = bus.awvalid & bus.awlock & excl_bad(bus.awaddr, bus.awsize);
      detect[6]   = (bus.awvalid & (bus.awburst == 2'b01) & crosses_4k(bus.awaddr, bus.awlen, bus.awsize)) |
                    (bus.arvalid & (bus.arburst == 2'b01) & crosses_4k(bus.araddr, bus.arlen, bus.arsize));
      detect[7]   = (bus.awvalid & (bus.awburst == 2'b10) & wrap_len_bad(bus.awlen)) |
                    (bus.arvalid & (bus.arburst == 2'b10) & wrap_len_bad(bus.arlen));
   end

   // A clear in the same cycle as a violation still lets that violation through.
   always_comb begin
      count_base = err_clr ? 16'h0000 : err_count;
      if (|detect && count_base != 16'hFFFF) begin
         count_base = count_base + 16'h0001;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         prev_v    <= '0;
         prev_r    <= '0;
         err_flags <= '0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         prev_v    <= cur_v;
         prev_r    <= cur_r;
         err_flags <= (err_clr ? 8'h00 : err_flags) | detect;
         err_pulse <= |detect;
         err_count <= count_base;
      end
   end
endmodule

// File: tb/tb_axi4_modport_checker.sv
// Self-checking bench for axi4_modport_checker: directed vector table, hand sequences,
// randomized traffic against a rule-level reference model, saturation and reset checks.
module tb_axi4_modport_checker;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;

   logic        aclk = 1'b0;
   logic        areset;
   logic        err_clr;
   logic [7:0]  err_flags;
   logic        err_pulse;
   logic [15:0] err_count;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   axi4_modport_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axi4_modport_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .bus       (bus),
      .err_clr   (err_clr),
      .err_flags (err_flags),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   typedef struct {
      string       name;
      logic        awv;
      logic        awlock;
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        arv;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t makeVec(string name, logic awv, logic awlock, logic [31:0] awaddr,
                                    logic [7:0] awlen, logic [2:0] awsize, logic [1:0] awburst,
                                    logic arv, logic [31:0] araddr, logic [7:0] arlen,
                                    logic [2:0] arsize, logic [1:0] arburst, logic [7:0] exp);
      vec_t v;
      v.name = name; v.awv = awv; v.awlock = awlock; v.awaddr = awaddr; v.awlen = awlen;
      v.awsize = awsize; v.awburst = awburst; v.arv = arv; v.araddr = araddr; v.arlen = arlen;
      v.arsize = arsize; v.arburst = arburst; v.exp = exp;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic idleBus();
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
      bus.awvalid = 1'b0; bus.awready = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.wready = 1'b0;
      bus.bid = '0; bus.bresp = '0; bus.bvalid = 1'b0; bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
      bus.arvalid = 1'b0; bus.arready = 1'b0;
      bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0; bus.rready = 1'b0;
   endtask

   // Readies are held high so each vector completes its handshake and cannot trip stability rules.
   task automatic applyStimulus(input vec_t v);
      bus.awvalid = v.awv; bus.awlock = v.awlock; bus.awaddr = v.awaddr; bus.awlen = v.awlen;
      bus.awsize = v.awsize; bus.awburst = v.awburst; bus.awready = 1'b1;
      bus.arvalid = v.arv; bus.araddr = v.araddr; bus.arlen = v.arlen;
      bus.arsize = v.arsize; bus.arburst = v.arburst; bus.arready = 1'b1;
   endtask

   // Reference rules expressed as byte arithmetic on page numbers and address residues.
   function automatic logic refCross(logic [31:0] addr, logic [7:0] len, logic [2:0] size);
      longint unsigned first, last;
      first = longint'(addr);
      last  = (first + (longint'(len) + 1) * (longint'(1) << size) - 1) % (longint'(1) << 32);
      return (first / 4096) != (last / 4096);
   endfunction

   function automatic logic refExclBad(logic [31:0] addr, logic [2:0] size);
      longint unsigned a;
      a = longint'(addr);
      return (size < 3) || ((a % (longint'(1) << size)) != 0);
   endfunction

   function automatic logic refWrapBad(logic [7:0] len);
      int beats;
      beats = int'(len) + 1;
      return !(beats == 2 || beats == 4 || beats == 8 || beats == 16);
   endfunction

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a[2:0] = 3'b000;
      return a;
   endfunction

   function automatic logic [7:0] randLen();
      return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16));
   endfunction

   logic [4:0]  mPendV;
   logic [4:0]  mPendR;
   logic [4:0]  curV;
   logic [4:0]  curR;
   logic [7:0]  mFlags;
   logic        mPulse;
   int          mCount;
   logic [7:0]  det;
   logic        clr;

   initial begin
      vecs.push_back(makeVec("excl_misaligned", 1, 1, 32'h1004, 0, 3, 2'b01, 0, 0, 0, 0, 0, 8'h20));
      vecs.push_back(makeVec("excl_aligned",    1, 1, 32'h1008, 0, 3, 2'b01, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(makeVec("excl_size2",      1, 1, 32'h1000, 0, 2, 2'b01, 0, 0, 0, 0, 0, 8'h20));
      vecs.push_back(makeVec("excl_lock0",      1, 0, 32'h1004, 0, 1, 2'b01, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(makeVec("ar_4k_cross",     0, 0, 0, 0, 0, 0, 1, 32'h0FF0, 3, 3, 2'b01, 8'h40));
      vecs.push_back(makeVec("ar_4k_edge",      0, 0, 0, 0, 0, 0, 1, 32'h0FE0, 3, 3, 2'b01, 8'h00));
      vecs.push_back(makeVec("aw_wrap_len2",    1, 0, 32'h0, 2, 0, 2'b10, 0, 0, 0, 0, 0, 8'h80));
      vecs.push_back(makeVec("aw_wrap_len3",    1, 0, 32'h0, 3, 0, 2'b10, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(makeVec("aw_fixed_len2",   1, 0, 32'hFF0, 2, 3, 2'b00, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(makeVec("aw_reserved",     1, 0, 32'hFFF, 2, 3, 2'b11, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(makeVec("ar_wrap_len15",   0, 0, 0, 0, 0, 0, 1, 32'h40, 15, 2, 2'b10, 8'h00));
      vecs.push_back(makeVec("ar_wrap_len16",   0, 0, 0, 0, 0, 0, 1, 32'h40, 16, 2, 2'b10, 8'h80));
      vecs.push_back(makeVec("aw_top_nocross",  1, 0, 32'hFFFF_FFF8, 0, 3, 2'b01, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(makeVec("aw_top_wrap",     1, 0, 32'hFFFF_FFF8, 1, 3, 2'b01, 0, 0, 0, 0, 0, 8'h40));
      vecs.push_back(makeVec("multi_rule",      1, 1, 32'h1004, 5, 3, 2'b10, 1, 32'h0FF0, 3, 3, 2'b01, 8'hE0));
      vecs.push_back(makeVec("invalid_fields",  0, 1, 32'h1003, 2, 0, 2'b10, 0, 32'h0FF0, 3, 3, 2'b10, 8'h00));

      idleBus();
      err_clr = 1'b1;
      areset  = 1'b1;
      repeat (2) @(negedge aclk);
      checkOutput("reset_flags", 32'(err_flags), 32'h00);
      checkOutput("reset_pulse", 32'(err_pulse), 32'h0);
      checkOutput("reset_count", 32'(err_count), 32'h0);
      areset  = 1'b0;
      err_clr = 1'b0;

      bus.awvalid = 1'b1; bus.awready = 1'b0;
      @(negedge aclk);
      checkOutput("aw_stall_ok_flags", 32'(err_flags), 32'h00);
      bus.awvalid = 1'b0;
      @(negedge aclk);
      checkOutput("aw_stab_flags", 32'(err_flags), 32'h01);
      checkOutput("aw_stab_pulse", 32'(err_pulse), 32'h1);
      checkOutput("aw_stab_count", 32'(err_count), 32'h1);
      @(negedge aclk);
      checkOutput("aw_stab_sticky", 32'(err_flags), 32'h01);
      checkOutput("aw_stab_pulse_drop", 32'(err_pulse), 32'h0);
      err_clr = 1'b1;
      @(negedge aclk);
      err_clr = 1'b0;
      checkOutput("clr_flags", 32'(err_flags), 32'h00);
      checkOutput("clr_count", 32'(err_count), 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         err_clr = 1'b1;
         @(negedge aclk);
         idleBus();
         err_clr = 1'b0;
         checkOutput({vecs[i].name, "_flags"}, 32'(err_flags), 32'(vecs[i].exp));
         checkOutput({vecs[i].name, "_pulse"}, 32'(err_pulse), 32'(vecs[i].exp != 0));
         checkOutput({vecs[i].name, "_count"}, 32'(err_count), 32'(vecs[i].exp != 0));
         @(negedge aclk);
      end

      bus.arvalid = 1'b1; bus.arready = 1'b0; bus.arburst = 2'b10; bus.arlen = 8'd2;
      err_clr = 1'b1;
      @(negedge aclk);
      err_clr = 1'b0;
      checkOutput("hold_ar_count1", 32'(err_count), 32'h1);
      repeat (2) @(negedge aclk);
      checkOutput("hold_ar_count3", 32'(err_count), 32'h3);
      checkOutput("hold_ar_flags", 32'(err_flags), 32'h80);
      bus.arready = 1'b1; bus.arburst = 2'b00;
      @(negedge aclk);
      idleBus();
      checkOutput("hold_ar_done_count", 32'(err_count), 32'h3);
      checkOutput("hold_ar_done_pulse", 32'(err_pulse), 32'h0);
      err_clr = 1'b1;
      @(negedge aclk);
      err_clr = 1'b0;
      checkOutput("hold_ar_clr_flags", 32'(err_flags), 32'h00);
      checkOutput("hold_ar_clr_count", 32'(err_count), 32'h0);

      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      mPendV = '0; mPendR = '0; mFlags = '0; mPulse = 1'b0; mCount = 0;
      for (int i = 0; i < 2000; i++) begin
         bus.awvalid = ($urandom_range(0, 2) != 0); bus.awready = $urandom_range(0, 1) == 1;
         bus.awlock  = ($urandom_range(0, 3) == 0);
         bus.awaddr  = randAddr(); bus.awlen = randLen();
         bus.awsize  = 3'($urandom_range(0, 7)); bus.awburst = 2'($urandom_range(0, 3));
         bus.arvalid = ($urandom_range(0, 2) != 0); bus.arready = $urandom_range(0, 1) == 1;
         bus.araddr  = randAddr(); bus.arlen = randLen();
         bus.arsize  = 3'($urandom_range(0, 7)); bus.arburst = 2'($urandom_range(0, 3));
         bus.wvalid  = $urandom_range(0, 1) == 1; bus.wready = $urandom_range(0, 1) == 1;
         bus.bvalid  = $urandom_range(0, 1) == 1; bus.bready = $urandom_range(0, 1) == 1;
         bus.rvalid  = $urandom_range(0, 1) == 1; bus.rready = $urandom_range(0, 1) == 1;
         bus.wdata   = {$urandom, $urandom};
         clr         = ($urandom_range(0, 15) == 0);
         err_clr     = clr;

         curV = {bus.rvalid, bus.bvalid, bus.arvalid, bus.wvalid, bus.awvalid};
         curR = {bus.rready, bus.bready, bus.arready, bus.wready, bus.awready};
         det = '0;
         for (int c = 0; c < 5; c++) begin
            if (mPendV[c] && !mPendR[c] && !curV[c]) det[c] = 1'b1;
         end
         if (bus.awvalid && bus.awlock && refExclBad(bus.awaddr, bus.awsize)) det[5] = 1'b1;
         if (bus.awvalid && bus.awburst == 2'b01 && refCross(bus.awaddr, bus.awlen, bus.awsize)) det[6] = 1'b1;
         if (bus.arvalid && bus.arburst == 2'b01 && refCross(bus.araddr, bus.arlen, bus.arsize)) det[6] = 1'b1;
         if (bus.awvalid && bus.awburst == 2'b10 && refWrapBad(bus.awlen)) det[7] = 1'b1;
         if (bus.arvalid && bus.arburst == 2'b10 && refWrapBad(bus.arlen)) det[7] = 1'b1;

         mFlags = (clr ? 8'h00 : mFlags) | det;
         mPulse = (det != 0);
         mCount = (clr ? 0 : mCount) + ((det != 0) ? 1 : 0);
         if (mCount > 65535) mCount = 65535;
         mPendV = curV;
         mPendR = curR;

         @(negedge aclk);
         checkOutput("rand_flags", 32'(err_flags), 32'(mFlags));
         checkOutput("rand_pulse", 32'(err_pulse), 32'(mPulse));
         checkOutput("rand_count", 32'(err_count), 32'(mCount));
      end

      idleBus();
      err_clr = 1'b0;
      areset  = 1'b1;
      @(negedge aclk);
      areset  = 1'b0;
      bus.arvalid = 1'b1; bus.arready = 1'b0; bus.arburst = 2'b10; bus.arlen = 8'd2;
      repeat (65534) @(negedge aclk);
      checkOutput("sat_count_fffe", 32'(err_count), 32'hFFFE);
      @(negedge aclk);
      checkOutput("sat_count_ffff", 32'(err_count), 32'hFFFF);
      repeat (70000 - 65535) @(negedge aclk);
      checkOutput("sat_count_hold", 32'(err_count), 32'hFFFF);
      checkOutput("sat_flags", 32'(err_flags), 32'h80);

      areset  = 1'b1;
      err_clr = 1'b1;
      @(negedge aclk);
      checkOutput("midreset_flags", 32'(err_flags), 32'h00);
      checkOutput("midreset_pulse", 32'(err_pulse), 32'h0);
      checkOutput("midreset_count", 32'(err_count), 32'h0);
      areset  = 1'b0;
      err_clr = 1'b0;
      bus.arvalid = 1'b0;
      @(negedge aclk);
      checkOutput("post_reset_no_stab", 32'(err_flags), 32'h00);
      checkOutput("post_reset_count", 32'(err_count), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
